// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: a Moore FSM that sequences FETCH, DECODE and
// the per-instruction execute/memory/writeback states. The instruction class
// and the R-type ALU operation are latched in DECODE. Outputs are a function
// of the state, except PCWrite in BRANCH (depends on zero) and illegal_o in
// DECODE (depends on the instruction).
// Optional feature: define BNE_EN to support bne (opcode 000101) through BRANCH.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [3:0] state_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  state_t     state_reg, state_next;
  state_t     decode_next;
  logic       decode_illegal;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic [3:0] alu_ctrl_reg;   // R-type ALU op captured in DECODE
  logic       is_store_reg;   // sw vs lw, captured in DECODE
  logic       is_bne_reg;     // branch polarity, captured in DECODE

  // Instruction decode: where DECODE goes next and whether the instruction is unsupported
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      6'b100111: funct_alu = ALU_NOR;
      default:   funct_ok  = 1'b0;
    endcase

    decode_next    = S_FETCH;
    decode_illegal = 1'b0;
    case (opcode)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct_ok) decode_next    = S_EXECUTE;
        else          decode_illegal = 1'b1;
      end
      OP_BEQ:       decode_next = S_BRANCH;
`ifdef BNE_EN
      OP_BNE:       decode_next = S_BRANCH;
`endif
      OP_ADDI:      decode_next = S_ADDIEXEC;
      default:      decode_illegal = 1'b1;
    endcase
  end

  // Next-state selection; unused encodings fall back to FETCH
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE:   state_next = decode_next;
      S_MEMADR:   state_next = is_store_reg ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = S_MEMWB;
      S_EXECUTE:  state_next = S_ALUWB;
      S_ADDIEXEC: state_next = S_ADDIWB;
      default:    state_next = S_FETCH;
    endcase
  end

  // State register plus the instruction attributes latched while in DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      alu_ctrl_reg <= ALU_ADD;
      is_store_reg <= 1'b0;
      is_bne_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        alu_ctrl_reg <= funct_alu;
        is_store_reg <= (opcode == OP_SW);
        is_bne_reg   <= (opcode == OP_BNE);
      end
    end
  end

  // Per-state control outputs; reset forces everything to 0 without waiting for clk
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 4'b0000;
    illegal_o  = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH: begin
          IRWrite    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          PCWrite    = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = ALU_ADD;
          illegal_o  = decode_illegal;
        end
        S_MEMADR, S_ADDIEXEC: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
        end
        S_MEMREAD: IorD = 1'b1;
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA    = 1'b1;
          ALUControl = alu_ctrl_reg;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSrc      = 1'b1;
          PCWrite    = is_bne_reg ? ~zero : zero;
        end
        S_ADDIWB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed scenarios followed by random
// instructions, each compared cycle by cycle against a per-instruction
// reference of expected state sequence and control values.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [3:0] state_o;
  logic       illegal_o;

  int total = 0;
  int bad   = 0;

`ifdef BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .state_o(state_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {state, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, ALUSrcB, ALUControl, illegal}
  function automatic logic [19:0] got_vec();
    return {state_o, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
            ALUSrcA, PCSrc, ALUSrcB, ALUControl, illegal_o};
  endfunction

  // Control values the document lists for each state
  function automatic logic [19:0] exp_vec(input int st, input logic [3:0] rt_alu,
                                          input logic take, input logic ill);
    logic pcw, iord, mw, irw, rd, m2r, rw, sa, ps, il;
    logic [1:0] sb;
    logic [3:0] ac;
    {pcw, iord, mw, irw, rd, m2r, rw, sa, ps, il} = '0;
    sb = 2'b00;
    ac = 4'b0000;
    case (st)
      0:  begin irw = 1; sb = 2'b01; ac = 4'b0010; pcw = 1; end
      1:  begin sb = 2'b11; ac = 4'b0010; il = ill; end
      2:  begin sa = 1; sb = 2'b10; ac = 4'b0010; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; sb = 2'b00; ac = rt_alu; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; sb = 2'b00; ac = 4'b0110; ps = 1; pcw = take; end
      9:  begin sa = 1; sb = 2'b10; ac = 4'b0010; end
      10: rw = 1;
      default: ;
    endcase
    return {st[3:0], pcw, iord, mw, irw, rd, m2r, rw, sa, ps, sb, ac, il};
  endfunction

  // Runs one instruction from its FETCH cycle; optionally asserts reset after
  // sampling cycle abort_at and checks that every output drops immediately.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int abort_at);
    int         seq[$];
    logic [3:0] alu;
    logic       fn_ok, take, ill;
    fn_ok = 1'b1;
    alu   = 4'b0000;
    case (fn)
      6'b100000: alu = 4'b0010;
      6'b100010: alu = 4'b0110;
      6'b100100: alu = 4'b0000;
      6'b100101: alu = 4'b0001;
      6'b101010: alu = 4'b0111;
      6'b100111: alu = 4'b1100;
      default:   fn_ok = 1'b0;
    endcase
    take = 1'b0;
    ill  = 1'b0;
    if (op == 6'b100011)                 seq = '{0, 1, 2, 3, 4};
    else if (op == 6'b101011)            seq = '{0, 1, 2, 5};
    else if (op == 6'b000000 && fn_ok)   seq = '{0, 1, 6, 7};
    else if (op == 6'b001000)            seq = '{0, 1, 9, 10};
    else if (op == 6'b000100) begin      seq = '{0, 1, 8}; take = z;  end
    else if (op == 6'b000101 && BNE_ON) begin seq = '{0, 1, 8}; take = ~z; end
    else begin                           seq = '{0, 1};    ill = 1'b1; end

    for (int c = 0; c < seq.size(); c++) begin
      @(negedge clk);
      check($sformatf("op%02h_fn%02h_z%0d_c%0d", op, fn, z, c), {12'd0, got_vec()},
            {12'd0, exp_vec(seq[c], alu, take, ill)});
      if (c == 0) begin
        opcode = op;
        funct  = fn;
        zero   = z;
      end
      if (c == abort_at) begin
        #1 reset = 1'b1;
        #1 check($sformatf("rst_async_op%02h_c%0d", op, c), {12'd0, got_vec()}, 32'd0);
        @(negedge clk);
        check("rst_hold", {12'd0, got_vec()}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        return;
      end
    end
  endtask

  logic [5:0] good_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

  initial begin
    logic [5:0] op, fn;
    int kind, abort_at;
    reset  = 1'b1;
    opcode = 6'd0;
    funct  = 6'd0;
    zero   = 1'b0;
    #2 check("rst_init", {12'd0, got_vec()}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed scenarios
    run_instr(6'b100011, 6'b000000, 1'b0, -1);  // lw
    run_instr(6'b000000, 6'b100010, 1'b0, -1);  // sub
    run_instr(6'b000100, 6'b000000, 1'b1, -1);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, -1);  // beq not taken
    run_instr(6'b111111, 6'b000000, 1'b0, -1);  // illegal opcode
    run_instr(6'b000000, 6'b000001, 1'b0, -1);  // illegal funct
    run_instr(6'b000101, 6'b000000, 1'b0, -1);  // bne, zero=0
    run_instr(6'b000101, 6'b000000, 1'b1, -1);  // bne, zero=1
    run_instr(6'b001000, 6'b000000, 1'b0, -1);  // addi
    run_instr(6'b101011, 6'b000000, 1'b0, 3);   // sw, reset in MEMWRITE
    run_instr(6'b101011, 6'b000000, 1'b0, -1);  // sw complete

    // Random instruction stream
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 7);
      fn   = 6'($urandom);
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = good_fn[$urandom_range(0, 5)]; end
        3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000101;
        default: op = 6'($urandom);
      endcase
      abort_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fn, 1'($urandom), abort_at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The module SHALL have no parameters; all encodings are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  Instr[31:26] from the instruction register.
REQ-005 funct  input  6  Instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag, combinational from the current ALU result.
REQ-007 PCWrite  output  1  PC register enable, already gated with branch/zero.
REQ-008 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc  output  1 each  datapath mux selects and enables.
REQ-009 ALUSrcB  output  2  select: 00 B, 01 constant 4, 10 SignImm, 11 SignImm<<2.
REQ-010 ALUControl  output  4  codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-011 state_o  output  4  current state encoding, for debug.
REQ-012 illegal_o  output  1  one-cycle pulse in DECODE when the instruction is unsupported.

Function
REQ-013 State encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10.
REQ-014 Outputs SHALL be Moore (a function of state only), except PCWrite in BRANCH and illegal_o in DECODE; every output not listed for a state SHALL be 0.
REQ-015 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=0, PCWrite=1; next state DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (branch target into ALUOut).
REQ-017 DECODE next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 (R-type) -> EXECUTE
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEXEC
- otherwise -> FETCH, with illegal_o=1
REQ-018 R-type funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR; any other funct is illegal (DECODE -> FETCH, illegal_o=1).
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD; next MEMREAD for lw, MEMWRITE for sw.
REQ-020 MEMREAD: IorD=1; next MEMWB.
REQ-021 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-022 MEMWRITE: IorD=1, MemWrite=1; next FETCH.
REQ-023 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl per funct decode; next ALUWB.
REQ-024 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=1, PCWrite=zero; next FETCH.
REQ-026 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD; next ADDIWB.
REQ-027 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-028 Unused encodings 11-15 SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-029 Cycle counts per instruction SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, illegal 2.

Reset
REQ-030 Asserting reset SHALL immediately force the state to FETCH, independent of clk.
REQ-031 While reset is high, all control outputs and illegal_o SHALL be 0; state_o SHALL read 0.
REQ-032 The first FETCH cycle SHALL occur after reset is released; reset mid-instruction abandons it, with no pending write completing.

Configuration
REQ-033 Macro BNE_EN:
- Defined: opcode 000101 (bne) goes DECODE -> BRANCH, and in BRANCH PCWrite=~zero for bne (zero for beq).
- Undefined: 000101 is illegal.
- A registered branch-type flag, captured in DECODE, SHALL select the polarity.

Verification
REQ-034 Reset then lw (opcode 100011): state_o sequence 0,1,2,3,4,0; IRWrite=1 only in cycle 1; MemtoReg=RegWrite=1 only in cycle 5.
REQ-035 R-type sub (funct 100010): EXECUTE shows ALUControl=0110, ALUSrcA=1, ALUSrcB=00; ALUWB shows RegDst=1, RegWrite=1.
REQ-036 beq with zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; with zero=0 -> PCWrite=0; both return to FETCH.
REQ-037 opcode 111111, or R-type with funct 000001 -> illegal_o=1 for one cycle in DECODE, next state FETCH, RegWrite and MemWrite never 1.
REQ-038 Reset asserted asynchronously while in MEMWRITE -> MemWrite drops to 0 before the next clk edge; state_o=0.
REQ-039 bne (000101) with zero=0: with BNE_EN -> PCWrite=1 in BRANCH; without -> illegal_o=1, no BRANCH state.
